// File: rtl/ps2_kbd_rx_pkg.sv
// ps2_kbd_rx_pkg: shared frame states, scan-code prefixes and the discard set
package ps2_kbd_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_DISCARD [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  function automatic logic is_discard(input logic [7:0] b);
    is_discard = 1'b0;
    for (int i = 0; i < 6; i++) if (b == PS2_DISCARD[i]) is_discard = 1'b1;
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and filters the PS/2 lines and deframes 11-bit frames into bytes
module ps2_frame_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 6400
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ps2,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       perr,
  output logic       tout
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  logic [1:0] s1, s2;
  logic fclk, fe, din, hit, ok, par;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  frame_state_t state, state_nxt;
  assign din  = s2[1];
  assign fe   = fclk && !s2[0] && fcnt == FMAX;
  assign hit  = state != IDLE && tcnt == TMAX && !fe;
  assign tout = hit;
  // odd parity: data plus parity bit must carry an odd number of ones
  assign ok   = din && ^{rx_byte, par};
  always_comb begin
    state_nxt = state;
    if (hit) state_nxt = IDLE;
    else if (fe)
      unique case (state)
        IDLE:    state_nxt = din ? IDLE : DATA;
        DATA:    state_nxt = bcnt == 3'd7 ? PARITY : DATA;
        PARITY:  state_nxt = STOP;
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1       <= 2'b11;
      s2       <= 2'b11;
      fclk     <= 1'b1;
      fcnt     <= '0;
      tcnt     <= '0;
      bcnt     <= '0;
      par      <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      perr     <= 1'b0;
      state    <= IDLE;
    end else begin
      s1       <= ps2;
      s2       <= s1;
      fcnt     <= (s2[0] == fclk || fcnt == FMAX) ? '0 : fcnt + 1'b1;
      fclk     <= (s2[0] != fclk && fcnt == FMAX) ? s2[0] : fclk;
      tcnt     <= (fe || state == IDLE) ? '0 : tcnt + 1'b1;
      bcnt     <= state == DATA ? bcnt + 3'(fe) : '0;
      par      <= (fe && state == PARITY) ? din : par;
      rx_byte  <= (fe && state == DATA) ? {din, rx_byte[7:1]} : rx_byte;
      rx_valid <= fe && state == STOP && ok;
      perr     <= fe && ((state == IDLE && din) || (state == STOP && !ok));
      state    <= state_nxt;
    end
  end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with set-2 prefix decoding into key events
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 6400,
  parameter int SKIP_E1 = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ps2,
  output logic       strb,
  output logic       make,
  output logic       ext,
  output logic [7:0] code,
  output logic       perr,
  output logic       tout
);
  localparam int SW = $clog2(SKIP_E1 + 1);
  logic [7:0] rx_byte;
  logic rx_valid, ext_p, brk_p;
  logic [SW-1:0] skip;
  ps2_frame_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_rx (
    .clock(clock), .reset(reset), .ps2(ps2),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .perr(perr), .tout(tout)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strb  <= 1'b0;
      make  <= 1'b0;
      ext   <= 1'b0;
      code  <= '0;
      ext_p <= 1'b0;
      brk_p <= 1'b0;
      skip  <= '0;
    end else begin
      strb <= 1'b0;
      if (perr || tout) begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
      end else if (rx_valid) begin
        // Pause sends a fixed-length tail that must not look like key events
        if (skip != '0) skip <= skip - 1'b1;
        else if (rx_byte == PS2_E1) skip <= SW'(SKIP_E1);
        else if (rx_byte == PS2_E0) ext_p <= 1'b1;
        else if (rx_byte == PS2_F0) brk_p <= 1'b1;
        else if (!is_discard(rx_byte)) begin
          code  <= rx_byte;
          make  <= !brk_p;
          ext   <= ext_p;
          strb  <= 1'b1;
          ext_p <= 1'b0;
          brk_p <= 1'b0;
        end
      end
    end
  end
endmodule
